// File: rtl/vslideup_seq.sv
// Sequencer around the combinational slide-up datapath: gathers vs2/vd groups from the
// register file, latches the datapath result, then writes the destination group back.
module vslideup_seq #(
    parameter int VLEN_BITS = 128
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_sew,
    input  logic                   req_lmul,
    input  logic [4:0]             req_uimm,
    input  logic [4:0]             req_vs2,
    input  logic [4:0]             req_vd,
    output logic                   rf_ren,
    output logic [4:0]             rf_raddr,
    input  logic [VLEN_BITS-1:0]   rf_rdata,
    output logic                   rf_we,
    output logic [4:0]             rf_waddr,
    output logic [VLEN_BITS-1:0]   rf_wdata,
    output logic                   su_sew,
    output logic                   su_lmul,
    output logic [4:0]             su_uimm,
    output logic [4*VLEN_BITS-1:0] su_vs2_bus,
    output logic [4*VLEN_BITS-1:0] su_vd_prev_bus,
    input  logic [4*VLEN_BITS-1:0] su_vd_bus,
    output logic                   busy,
    output logic                   done
);
    // state | meaning
    // IDLE  | waiting for a request, all latched fields zero
    // RD    | 2N reads: vs2 group then vd group
    // WAIT  | last read data returns
    // EXEC  | datapath result latched
    // WR    | N write-backs, done on the last
    typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_EXEC, S_WR} state_t;

    localparam int GRP_BITS = 4 * VLEN_BITS;

    state_t              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                sew_q, lmul_q;
    logic [4:0]          uimm_q, vs2_q, vd_q;
    logic                cap_vld_q;
    logic [2:0]          cap_idx_q;
    logic [GRP_BITS-1:0] vs2_bus_q, vdp_bus_q, res_q;

    logic                rd_last, wr_last, rd_is_vs2, cap_is_vs2;
    logic [1:0]          rd_off, cap_slice;

    assign rd_last    = (cnt_q == (lmul_q ? 3'd7 : 3'd1));
    assign wr_last    = (cnt_q == (lmul_q ? 3'd3 : 3'd0));
    assign rd_is_vs2  = lmul_q ? ~cnt_q[2] : ~cnt_q[0];
    assign rd_off     = lmul_q ? cnt_q[1:0] : 2'd0;
    // Read data lags its request by one cycle, so capture uses the delayed read index.
    assign cap_is_vs2 = lmul_q ? ~cap_idx_q[2] : ~cap_idx_q[0];
    assign cap_slice  = lmul_q ? cap_idx_q[1:0] : 2'd0;

    assign su_sew         = sew_q;
    assign su_lmul        = lmul_q;
    assign su_uimm        = uimm_q;
    assign su_vs2_bus     = vs2_bus_q;
    assign su_vd_prev_bus = vdp_bus_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        rf_ren    = 1'b0;
        rf_raddr  = '0;
        rf_we     = 1'b0;
        rf_waddr  = '0;
        rf_wdata  = '0;
        unique case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                cnt_d     = 3'd0;
                if (req_valid) state_d = S_RD;
            end
            S_RD: begin
                rf_ren   = 1'b1;
                rf_raddr = (rd_is_vs2 ? vs2_q : vd_q) + {3'b000, rd_off};
                cnt_d    = cnt_q + 3'd1;
                if (rd_last) begin
                    state_d = S_WAIT;
                    cnt_d   = 3'd0;
                end
            end
            S_WAIT: state_d = S_EXEC;
            S_EXEC: begin
                state_d = S_WR;
                cnt_d   = 3'd0;
            end
            S_WR: begin
                rf_we    = 1'b1;
                rf_waddr = vd_q + {3'b000, cnt_q[1:0]};
                for (int s = 0; s < 4; s++) begin
                    if (cnt_q[1:0] == 2'(s)) rf_wdata = res_q[s*VLEN_BITS +: VLEN_BITS];
                end
                cnt_d = cnt_q + 3'd1;
                if (wr_last) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            sew_q     <= 1'b0;
            lmul_q    <= 1'b0;
            uimm_q    <= '0;
            vs2_q     <= '0;
            vd_q      <= '0;
            cap_vld_q <= 1'b0;
            cap_idx_q <= '0;
            vs2_bus_q <= '0;
            vdp_bus_q <= '0;
            res_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cap_vld_q <= (state_q == S_RD);
            cap_idx_q <= cnt_q;
            if (state_q == S_IDLE && req_valid) begin
                sew_q     <= req_sew;
                lmul_q    <= req_lmul;
                uimm_q    <= req_uimm;
                vs2_q     <= req_lmul ? {req_vs2[4:2], 2'b00} : req_vs2;
                vd_q      <= req_lmul ? {req_vd[4:2], 2'b00} : req_vd;
                vs2_bus_q <= '0;
                vdp_bus_q <= '0;
            end
            if (cap_vld_q) begin
                for (int s = 0; s < 4; s++) begin
                    if (cap_slice == 2'(s)) begin
                        if (cap_is_vs2) vs2_bus_q[s*VLEN_BITS +: VLEN_BITS] <= rf_rdata;
                        else            vdp_bus_q[s*VLEN_BITS +: VLEN_BITS] <= rf_rdata;
                    end
                end
            end
            if (state_q == S_EXEC) res_q <= su_vd_bus;
            // Returning to IDLE clears every latched field so idle outputs read as zero.
            if (done) begin
                sew_q     <= 1'b0;
                lmul_q    <= 1'b0;
                uimm_q    <= '0;
                vs2_q     <= '0;
                vd_q      <= '0;
                vs2_bus_q <= '0;
                vdp_bus_q <= '0;
                res_q     <= '0;
            end
        end
    end
endmodule

// File: tb/tb_vslideup_seq.sv
// Self-checking bench for vslideup_seq: register-file model, behavioural slide-up
// datapath, and a cycle-stamped scoreboard of expected reads and writes.
module tb_vslideup_seq;
    localparam int VL = 128;
    localparam int GB = 4 * VL;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_sew, req_lmul;
    logic [4:0]    req_uimm, req_vs2, req_vd;
    logic          rf_ren, rf_we;
    logic [4:0]    rf_raddr, rf_waddr;
    logic [VL-1:0] rf_rdata, rf_wdata;
    logic          su_sew, su_lmul;
    logic [4:0]    su_uimm;
    logic [GB-1:0] su_vs2_bus, su_vd_prev_bus, su_vd_bus;
    logic          busy, done;

    typedef struct {
        int            cyc;
        bit            wr;
        logic [4:0]    addr;
        logic [VL-1:0] data;
    } ev_t;

    ev_t           evq[$];
    logic [VL-1:0] mem [32];
    int            checks = 0;
    int            errors = 0;

    vslideup_seq #(.VLEN_BITS(VL)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_sew(req_sew), .req_lmul(req_lmul),
        .req_uimm(req_uimm), .req_vs2(req_vs2), .req_vd(req_vd),
        .rf_ren(rf_ren), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .su_sew(su_sew), .su_lmul(su_lmul), .su_uimm(su_uimm),
        .su_vs2_bus(su_vs2_bus), .su_vd_prev_bus(su_vd_prev_bus), .su_vd_bus(su_vd_bus),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [GB-1:0] slide(input logic sew, input logic lmul, input logic [4:0] uimm,
                                            input logic [GB-1:0] src, input logic [GB-1:0] old);
        logic [GB-1:0] r;
        int ne;
        r  = old;
        ne = (lmul ? GB : VL) / (sew ? 32 : 8);
        for (int i = 0; i < ne; i++) begin
            if (i >= int'(uimm)) begin
                if (sew) r[i*32 +: 32] = src[(i-int'(uimm))*32 +: 32];
                else     r[i*8 +: 8]   = src[(i-int'(uimm))*8 +: 8];
            end
        end
        return r;
    endfunction

    always_comb su_vd_bus = slide(su_sew, su_lmul, su_uimm, su_vs2_bus, su_vd_prev_bus);

    // Register file: one-cycle read latency, write on the clock edge.
    always @(posedge clk) begin
        if (rf_we) mem[rf_waddr] = rf_wdata;
        if (rf_ren) rf_rdata <= mem[rf_raddr];
    end

    // Called at a negedge in the accept cycle; returns at the negedge of cycle 3N+3.
    task automatic run_req(input logic sew, input logic lmul, input logic [4:0] uimm,
                           input logic [4:0] vs2, input logic [4:0] vd, input bit hold,
                           output logic [GB-1:0] exp_o);
        int n;
        logic [4:0] vs2a, vda;
        logic [GB-1:0] src, old;
        ev_t e;
        bit fin;
        n    = lmul ? 4 : 1;
        vs2a = lmul ? {vs2[4:2], 2'b00} : vs2;
        vda  = lmul ? {vd[4:2], 2'b00} : vd;
        src  = '0;
        old  = '0;
        for (int k = 0; k < n; k++) begin
            src[k*VL +: VL] = mem[vs2a + 5'(k)];
            old[k*VL +: VL] = mem[vda + 5'(k)];
        end
        exp_o = slide(sew, lmul, uimm, src, old);
        for (int j = 0; j < n; j++) evq.push_back('{1 + j, 1'b0, vs2a + 5'(j), '0});
        for (int j = 0; j < n; j++) evq.push_back('{1 + n + j, 1'b0, vda + 5'(j), '0});
        for (int k = 0; k < n; k++) evq.push_back('{2*n + 3 + k, 1'b1, vda + 5'(k), exp_o[k*VL +: VL]});
        req_sew = sew; req_lmul = lmul; req_uimm = uimm; req_vs2 = vs2; req_vd = vd;
        req_valid = 1'b1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL accept_ready got %b want 1", req_ready);
        end
        fin = 0;
        for (int c = 1; c <= 3*n + 6 && !fin; c++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b1 || req_ready !== 1'b0 || (rf_ren && rf_we)) begin
                errors++;
                $display("FAIL busy_phase cyc %0d busy %b ready %b ren %b we %b want 1 0 and not both", c, busy, req_ready, rf_ren, rf_we);
            end
            if (rf_ren === 1'b1 || rf_we === 1'b1) begin
                checks++;
                if (evq.size() == 0) begin
                    errors++; $display("FAIL unexpected_access cyc %0d ren %b we %b", c, rf_ren, rf_we);
                end else begin
                    e = evq.pop_front();
                    if (e.cyc != c || e.wr != rf_we || e.addr !== (e.wr ? rf_waddr : rf_raddr) ||
                        (e.wr && rf_wdata !== e.data)) begin
                        errors++;
                        $display("FAIL access cyc %0d we %b raddr %0d waddr %0d wdata %h ; want cyc %0d we %b addr %0d data %h",
                                 c, rf_we, rf_raddr, rf_waddr, rf_wdata, e.cyc, e.wr, e.addr, e.data);
                    end
                end
            end
            if (done === 1'b1) begin
                fin = 1;
                checks++;
                if (c != 3*n + 2) begin
                    errors++; $display("FAIL done_cycle got %0d want %0d", c, 3*n + 2);
                end
            end
            if (c == 1 && !hold) begin
                req_valid = 1'b0;
                req_uimm  = 5'($urandom);
                req_vs2   = 5'($urandom);
                req_vd    = 5'($urandom);
            end
        end
        checks++;
        if (!fin) begin
            errors++; $display("FAIL done_timeout got no done want done in cycle %0d", 3*n + 2);
        end
        checks++;
        if (evq.size() != 0) begin
            errors++; $display("FAIL missing_accesses got %0d left want 0", evq.size());
            evq.delete();
        end
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || rf_raddr !== 5'd0 || su_uimm !== 5'd0 ||
            su_lmul !== 1'b0 || su_vs2_bus !== '0 || su_vd_prev_bus !== '0) begin
            errors++;
            $display("FAIL idle_after ready %b busy %b raddr %0d uimm %0d lmul %b ; want 1 0 0 0 0 and zero buses",
                     req_ready, busy, rf_raddr, su_uimm, su_lmul);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || rf_ren !== 1'b0 || rf_we !== 1'b0 ||
            rf_waddr !== 5'd0 || rf_wdata !== '0 || su_sew !== 1'b0 || su_uimm !== 5'd0 ||
            su_vs2_bus !== '0 || su_vd_prev_bus !== '0) begin
            errors++;
            $display("FAIL reset_outputs ready %b busy %b done %b ren %b we %b ; want 1 0 0 0 0 and zeros",
                     req_ready, busy, done, rf_ren, rf_we);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_int8();
        logic [GB-1:0] ex;
        mem[2] = 128'h0F0E0D0C0B0A09080706050403020100;
        mem[5] = 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0;
        run_req(1'b0, 1'b0, 5'd3, 5'd2, 5'd5, 1'b0, ex);
        checks++;
        if (mem[5] !== 128'h0C0B0A09080706050403020100A2A1A0) begin
            errors++; $display("FAIL int8_result got %h want %h", mem[5], 128'h0C0B0A09080706050403020100A2A1A0);
        end
    endtask

    task automatic test_group_int32();
        logic [GB-1:0] ex;
        logic [VL-1:0] want;
        for (int k = 0; k < 4; k++) begin
            for (int w = 0; w < 4; w++) begin
                mem[8 + k][w*32 +: 32]  = 32'(4*k + w);
                mem[12 + k][w*32 +: 32] = 32'hC000_0000 + 32'(4*k + w);
            end
        end
        run_req(1'b1, 1'b1, 5'd5, 5'd8, 5'd13, 1'b0, ex);
        for (int k = 0; k < 4; k++) begin
            for (int w = 0; w < 4; w++) begin
                if (4*k + w < 5) want[w*32 +: 32] = 32'hC000_0000 + 32'(4*k + w);
                else             want[w*32 +: 32] = 32'(4*k + w - 5);
            end
            checks++;
            if (mem[12 + k] !== want) begin
                errors++; $display("FAIL int32_group v%0d got %h want %h", 12 + k, mem[12 + k], want);
            end
        end
    endtask

    task automatic test_uimm_edges();
        logic [GB-1:0] ex;
        logic [VL-1:0] snap;
        snap = mem[3];
        run_req(1'b1, 1'b0, 5'd0, 5'd3, 5'd6, 1'b0, ex);
        checks++;
        if (mem[6] !== snap) begin
            errors++; $display("FAIL uimm0_copy got %h want %h", mem[6], snap);
        end
        snap = mem[7];
        run_req(1'b1, 1'b0, 5'd7, 5'd1, 5'd7, 1'b0, ex);
        checks++;
        if (mem[7] !== snap) begin
            errors++; $display("FAIL uimm_big_unchanged got %h want %h", mem[7], snap);
        end
    endtask

    task automatic test_overlap();
        logic [GB-1:0] ex;
        logic [VL-1:0] snap, want;
        snap = mem[4];
        want = {snap[111:0], snap[15:0]};
        run_req(1'b0, 1'b0, 5'd2, 5'd4, 5'd4, 1'b0, ex);
        checks++;
        if (mem[4] !== want) begin
            errors++; $display("FAIL overlap got %h want %h", mem[4], want);
        end
    endtask

    task automatic test_reset_mid();
        logic [GB-1:0] src, old, ex;
        bit bad;
        for (int k = 0; k < 4; k++) begin
            src[k*VL +: VL] = mem[16 + k];
            old[k*VL +: VL] = mem[20 + k];
        end
        ex = slide(1'b1, 1'b1, 5'd2, src, old);
        req_sew = 1'b1; req_lmul = 1'b1; req_uimm = 5'd2; req_vs2 = 5'd16; req_vd = 5'd20;
        req_valid = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd21) begin
            errors++; $display("FAIL mid_wr_active got we %b addr %0d want 1 21", rf_we, rf_waddr);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (rf_we !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL async_reset got we %b ready %b busy %b done %b want 0 1 0 0", rf_we, req_ready, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rf_we || rf_ren || done || busy) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL post_reset_quiet got activity want none");
        end
        checks++;
        if (mem[20] !== ex[0 +: VL] || mem[21] !== old[VL +: VL] || mem[22] !== old[2*VL +: VL] || mem[23] !== old[3*VL +: VL]) begin
            errors++; $display("FAIL partial_group got v20 %h v21 %h want v20 %h v21 %h", mem[20], mem[21], ex[0 +: VL], old[VL +: VL]);
        end
        run_req(1'b0, 1'b1, 5'd9, 5'd16, 5'd20, 1'b0, ex);
        checks++;
        if ({mem[23], mem[22], mem[21], mem[20]} !== ex) begin
            errors++; $display("FAIL after_reset_req got %h want %h", mem[20], ex[0 +: VL]);
        end
    endtask

    task automatic test_back_to_back();
        logic [GB-1:0] ex;
        run_req(1'b0, 1'b0, 5'd1, 5'd9, 5'd10, 1'b1, ex);
        run_req(1'b0, 1'b0, 5'd1, 5'd9, 5'd10, 1'b1, ex);
        run_req(1'b1, 1'b1, 5'd3, 5'd24, 5'd28, 1'b0, ex);
        checks++;
        if ({mem[31], mem[30], mem[29], mem[28]} !== ex) begin
            errors++; $display("FAIL b2b_group got %h want %h", mem[28], ex[0 +: VL]);
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_sew = 1'b0; req_lmul = 1'b0;
        req_uimm = '0; req_vs2 = '0; req_vd = '0;
        for (int r = 0; r < 32; r++) mem[r] = {$urandom, $urandom, $urandom, $urandom};
        test_reset();
        test_basic_int8();
        test_group_int32();
        test_uimm_edges();
        test_overlap();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
